// File: rtl/serdes_lane_packer_if.sv
// Record-input bus of serdes_lane_packer: write strobe, type, payload and the FIFO-full back-pressure flag.
interface serdes_lane_packer_if #(
    parameter int REC_W = 48
);
    logic             I_rec_ena;
    logic [1:0]       I_rec_type;
    logic [REC_W-1:0] I_rec_dat;
    logic             O_fifo_full;

    modport master (output I_rec_ena, I_rec_type, I_rec_dat, input O_fifo_full);
    modport slave  (input I_rec_ena, I_rec_type, I_rec_dat, output O_fifo_full);
endinterface

// File: rtl/serdes_lane_packer.sv
// Record FIFO + packetiser striping 16-bit words across NUM_LANES serdes lanes with K-char framing.
// Define SERDES_PKT_CHECKSUM_EN to carry the payload XOR checksum in the EOF beat.
module serdes_lane_packer #(
    parameter int NUM_LANES    = 4,
    parameter int REC_W        = 48,
    parameter int FIFO_AW      = 6,
    parameter int RECS_PER_PKT = 16,
    parameter int TIMEOUT      = 32,
    parameter int IDLE_GAP     = 2
) (
    input  logic                   I_sys_clk,
    input  logic                   I_rst_n,
    serdes_lane_packer_if.slave    rec,
    input  logic                   I_tx_en,
    output logic [15:0]            O_ovf_cnt,
    output logic [NUM_LANES-1:0]   O_tx_is_k,
    output logic [16*NUM_LANES-1:0] O_tx_dat,
    output logic                   O_pkt_busy,
    output logic [7:0]             O_seq
);
    localparam int WPR   = REC_W / 16;
    localparam int CAP   = NUM_LANES + WPR - 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CAP + 1);

    typedef struct packed {
        logic [1:0]       typ;
        logic [REC_W-1:0] dat;
    } rec_t;

    typedef enum logic [1:0] {IDLE, HDR, PAY, EOF} state_t;

    // ---------------- record FIFO ----------------
    rec_t               mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               full_q;
    logic [15:0]        ovf_q;
    rec_t               head;
    logic               empty, wr_en, pop;

    assign wr_en = rec.I_rec_ena && !full_q;
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge I_sys_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {rec.I_rec_type, rec.I_rec_dat};
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge I_sys_clk) begin
        if (!I_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            ovf_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == (FIFO_AW+1)'(DEPTH));
            if (rec.I_rec_ena && full_q && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 1'b1;
        end
    end

    // ---------------- packetiser ----------------
    state_t                       state_q;
    logic [1:0]                   pkt_type_q;
    logic [7:0]                   seq_q, rec_cnt_q, gap_q;
    logic [15:0]                  tmo_q;
    logic [CAP-1:0][15:0]         buf_q, buf_d;
    logic [CW-1:0]                buf_cnt_q, buf_cnt_d;
    logic [NUM_LANES-1:0]         tx_k_q;
    logic [NUM_LANES-1:0][15:0]   tx_dat_q, lane_w;
    logic                         busy_q;
    logic [WPR-1:0][15:0]         rec_w;
    logic                         close, data_beat, last_beat, gap_ok;
    int                           bcnt, cons, after;

    // rec_w[WPR-1] holds the payload MSBs, i.e. word0
    assign rec_w = head.dat;

    always_comb begin
        bcnt  = int'(buf_cnt_q);
        close = (int'(rec_cnt_q) >= RECS_PER_PKT) ||
                (!empty && head.typ != pkt_type_q) ||
                (empty && int'(tmo_q) >= TIMEOUT - 1) ||
                !I_tx_en;
        cons = 0;
        if (state_q == PAY) begin
            if (bcnt >= NUM_LANES) cons = NUM_LANES;
            else if (close)        cons = bcnt;
        end
        after     = bcnt - cons;
        data_beat = (state_q == PAY) && (cons != 0);
        // More than one beat left at close keeps draining before the final beat
        last_beat = (state_q == PAY) && close && (bcnt <= NUM_LANES);
        pop       = (state_q == PAY) && !close && !empty && (after + WPR <= CAP);

        buf_d = '0;
        for (int i = 0; i < CAP; i++)
            for (int k = 0; k < CAP; k++)
                if (k == i + cons) buf_d[i] = buf_q[k];
        if (pop) begin
            for (int i = 0; i < CAP; i++)
                for (int j = 0; j < WPR; j++)
                    if (i == after + j) buf_d[i] = rec_w[WPR-1-j];
        end
        buf_cnt_d = CW'(after + (pop ? WPR : 0));

        lane_w = '0;
        for (int n = 0; n < NUM_LANES; n++)
            if (n < bcnt) lane_w[n] = buf_q[n];

        gap_ok = (int'(gap_q) + 1 >= IDLE_GAP);
    end

`ifdef SERDES_PKT_CHECKSUM_EN
    logic [15:0] chk_q, rec_xor;

    always_comb begin
        rec_xor = '0;
        for (int j = 0; j < WPR; j++) rec_xor = rec_xor ^ rec_w[j];
    end
`endif

    always_ff @(posedge I_sys_clk) begin
        if (!I_rst_n) begin
            state_q    <= IDLE;
            pkt_type_q <= '0;
            seq_q      <= '0;
            rec_cnt_q  <= '0;
            gap_q      <= '0;
            tmo_q      <= '0;
            buf_q      <= '0;
            buf_cnt_q  <= '0;
            tx_k_q     <= '1;
            tx_dat_q   <= {NUM_LANES{16'h50BC}};
            busy_q     <= 1'b0;
`ifdef SERDES_PKT_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            buf_q     <= buf_d;
            buf_cnt_q <= buf_cnt_d;
            case (state_q)
                IDLE: begin
                    tx_k_q   <= '1;
                    tx_dat_q <= {NUM_LANES{16'h50BC}};
                    busy_q   <= 1'b0;
                    if (gap_q != 8'hFF) gap_q <= gap_q + 1'b1;
                    if (!empty && I_tx_en && gap_ok) begin
                        pkt_type_q <= head.typ;
                        state_q    <= HDR;
                    end
                end
                HDR: begin
                    tx_k_q      <= NUM_LANES'(1);
                    tx_dat_q    <= '0;
                    tx_dat_q[0] <= {seq_q, 8'hFB};
                    tx_dat_q[1] <= {14'd0, pkt_type_q};
                    busy_q      <= 1'b1;
                    rec_cnt_q   <= '0;
                    tmo_q       <= '0;
`ifdef SERDES_PKT_CHECKSUM_EN
                    chk_q       <= '0;
`endif
                    state_q     <= PAY;
                end
                PAY: begin
                    busy_q <= 1'b1;
                    if (data_beat) begin
                        tx_k_q   <= '0;
                        tx_dat_q <= lane_w;
                    end else begin
                        tx_k_q   <= '1;
                        tx_dat_q <= {NUM_LANES{16'h3C3C}};
                    end
                    if (pop) begin
                        rec_cnt_q <= rec_cnt_q + 1'b1;
                        tmo_q     <= '0;
`ifdef SERDES_PKT_CHECKSUM_EN
                        chk_q     <= chk_q ^ rec_xor;
`endif
                    end else if (!empty) begin
                        tmo_q <= '0;
                    end else if (tmo_q != 16'hFFFF) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                    if (last_beat) state_q <= EOF;
                end
                EOF: begin
                    tx_k_q      <= NUM_LANES'(1);
                    tx_dat_q    <= '0;
                    tx_dat_q[0] <= {rec_cnt_q, 8'hFD};
`ifdef SERDES_PKT_CHECKSUM_EN
                    tx_dat_q[1] <= chk_q;
`else
                    tx_dat_q[1] <= 16'h0000;
`endif
                    busy_q      <= 1'b1;
                    seq_q       <= seq_q + 1'b1;
                    gap_q       <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign O_tx_is_k       = tx_k_q;
    assign O_tx_dat        = tx_dat_q;
    assign O_pkt_busy      = busy_q;
    assign O_seq           = seq_q;
    assign O_ovf_cnt       = ovf_q;
    assign rec.O_fifo_full = full_q;

endmodule
